// File: rtl/seq_pkg.sv
// Shared types for the bit serializer and its 1011 detector bench.
// Holds the serializer FSM states and the detector pattern.
package seq_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  localparam logic [3:0] SEQ_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_hold_reg.sv
// One-entry holding buffer in front of the serializer shifter.
// Ports: clk, reset (sync, active low), wr_en/wr_data, rd_en/rd_data, full.
module seq_hold_reg
  import seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  logic [WIDTH-1:0] data_q;
  logic             full_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (wr_en) data_q <= wr_data;
      full_q <= wr_en | (full_q & ~rd_en);
    end
  end

  assign rd_data = data_q;
  assign full    = full_q;

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the 1011 sequence detector.
// Ports: in_data/in_valid/in_ready word handshake, stall, out_bit/out_valid/out_last.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_t       state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [CW-1:0]    cnt_q;

  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             accept;
  logic             shifting;
  logic             last_edge;
  logic             hold_wr;
  logic             hold_rd;
  logic [WIDTH-1:0] sreg_sh;
  logic             head;

  assign in_ready  = reset & ~hold_full;
  assign accept    = in_valid & in_ready;
  assign shifting  = (state_q == SER_SHIFT);
  assign last_edge = shifting & ~stall & (cnt_q == LAST);

  // The held word goes straight into the shifter on the last-bit edge;
  // any other accept while shifting parks in the hold register.
  assign hold_rd = last_edge & hold_full;
  assign hold_wr = accept & shifting & ~last_edge;

  assign sreg_sh = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
  assign head    = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

  seq_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (hold_wr),
    .wr_data(in_data),
    .rd_en  (hold_rd),
    .rd_data(hold_data),
    .full   (hold_full)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SER_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        SER_IDLE: begin
          if (accept) begin
            sreg_q  <= in_data;
            cnt_q   <= '0;
            state_q <= SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (!stall) begin
            if (cnt_q == LAST) begin
              cnt_q <= '0;
              if (hold_full) begin
                sreg_q <= hold_data;
              end else if (accept) begin
                sreg_q <= in_data;
              end else begin
                sreg_q  <= sreg_sh;
                state_q <= SER_IDLE;
              end
            end else begin
              sreg_q <= sreg_sh;
              cnt_q  <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= SER_IDLE;
      endcase
    end
  end

  assign out_valid = shifting;
  assign out_bit   = shifting & head;
  assign out_last  = shifting & (cnt_q == LAST);

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer.
// Three instances: 8-bit MSB-first, 8-bit LSB-first, 4-bit MSB-first.
module tb_seq_bit_serializer;
  import seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] d8, dl;
  logic [3:0] d4;
  logic       v8, vl, v4, st, st0;
  logic       r8, rl, r4;
  logic       b8, bl, b4;
  logic       ov8, ovl, ov4;
  logic       ol8, oll, ol4;

  int vectors = 0;
  int miscompares = 0;
  int vc8 = 0, vcl = 0, vc4 = 0;
  int l4 = 0, m4 = 0, n4 = 0;
  logic [3:0] hist4;

  logic [1:0] q8[$];
  logic [1:0] ql[$];
  logic [1:0] q4[$];

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u8 (
    .clk(clk), .reset(rst_n), .in_data(d8), .in_valid(v8),
    .in_ready(r8), .stall(st), .out_bit(b8),
    .out_valid(ov8), .out_last(ol8)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) ul (
    .clk(clk), .reset(rst_n), .in_data(dl), .in_valid(vl),
    .in_ready(rl), .stall(st0), .out_bit(bl),
    .out_valid(ovl), .out_last(oll)
  );

  seq_bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u4 (
    .clk(clk), .reset(rst_n), .in_data(d4), .in_valid(v4),
    .in_ready(r4), .stall(st0), .out_bit(b4),
    .out_valid(ov4), .out_last(ol4)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: push expected {last,bit} on accept, pop on a consumed bit.
  always @(posedge clk) begin
    if (!rst_n) begin
      q8.delete();
      ql.delete();
      q4.delete();
    end else begin
      if (ov8 && !st && q8.size() > 0) void'(q8.pop_front());
      if (ovl && ql.size() > 0) void'(ql.pop_front());
      if (ov4 && q4.size() > 0) begin
        void'(q4.pop_front());
        hist4 = {hist4[2:0], b4};
        n4++;
        if (n4 >= 4 && hist4 == SEQ_PATTERN) m4++;
      end
      if (v8 && r8)
        for (int i = 7; i >= 0; i--) q8.push_back({i == 0, d8[i]});
      if (vl && rl)
        for (int i = 0; i < 8; i++) ql.push_back({i == 7, dl[i]});
      if (v4 && r4)
        for (int i = 3; i >= 0; i--) q4.push_back({i == 0, d4[i]});
    end
  end

  always @(negedge clk) begin
    chk("valid8", 32'(ov8), 32'(q8.size() != 0));
    if (ov8 && q8.size() > 0) begin
      chk("bit8", 32'(b8), 32'(q8[0][0]));
      chk("last8", 32'(ol8), 32'(q8[0][1]));
      vc8++;
    end else if (!ov8) begin
      chk("idle8", 32'({ol8, b8}), 32'd0);
    end
    chk("validL", 32'(ovl), 32'(ql.size() != 0));
    if (ovl && ql.size() > 0) begin
      chk("bitL", 32'(bl), 32'(ql[0][0]));
      chk("lastL", 32'(oll), 32'(ql[0][1]));
      vcl++;
    end
    chk("valid4", 32'(ov4), 32'(q4.size() != 0));
    if (ov4 && q4.size() > 0) begin
      chk("bit4", 32'(b4), 32'(q4[0][0]));
      chk("last4", 32'(ol4), 32'(q4[0][1]));
      vc4++;
      if (ol4) l4++;
    end
  end

  task automatic send(input int sel, input logic [7:0] d,
                      output int waited);
    logic rdy;
    int n;
    n = 0;
    rdy = 1'b0;
    case (sel)
      0: begin d8 = d; v8 = 1'b1; end
      1: begin dl = d; vl = 1'b1; end
      default: begin d4 = d[3:0]; v4 = 1'b1; end
    endcase
    do begin
      @(posedge clk);
      rdy = (sel == 0) ? r8 : (sel == 1) ? rl : r4;
      n++;
    end while (!rdy && n < 100);
    #1;
    chk("accept", 32'(rdy), 32'd1);
    waited = n;
  endtask

  task automatic idle();
    v8 = 1'b0;
    vl = 1'b0;
    v4 = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int w;

  initial begin
    rst_n = 1'b0;
    {v8, vl, v4, st, st0} = '0;
    d8 = '0; dl = '0; d4 = '0;
    hist4 = '0;
    repeat (2) @(posedge clk);
    #1;
    v8 = 1'b1;
    d8 = 8'h5A;
    @(posedge clk);
    #1;
    chk("rdy_in_reset", 32'(r8), 32'd0);
    v8 = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rdy_release", 32'(r8), 32'd1);

    // single word
    vc8 = 0;
    send(0, 8'hB0, w);
    idle();
    drain(12);
    chk("t1_valid_cycles", 32'(vc8), 32'd8);

    // back-to-back with hold register
    vc8 = 0;
    send(0, 8'hB0, w);
    send(0, 8'h0B, w);
    chk("rdy_hold_full", 32'(r8), 32'd0);
    send(0, 8'hFF, w);
    chk("hold_load_wait", 32'(w), 32'd8);
    idle();
    drain(26);
    chk("t2_valid_cycles", 32'(vc8), 32'd24);

    // stall on third bit
    vc8 = 0;
    send(0, 8'hB0, w);
    idle();
    drain(2);
    st = 1'b1;
    repeat (4) begin
      chk("stall_bit", 32'(b8), 32'd1);
      @(posedge clk);
      #1;
    end
    chk("stall_bit_end", 32'(b8), 32'd1);
    st = 1'b0;
    drain(12);
    chk("t3_valid_cycles", 32'(vc8), 32'd12);

    // reset mid-word with hold full
    send(0, 8'hB0, w);
    send(0, 8'h0B, w);
    idle();
    drain(4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(ov8), 32'd0);
    chk("rst_bit", 32'(b8), 32'd0);
    chk("rst_rdy", 32'(r8), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy_after", 32'(r8), 32'd1);
    vc8 = 0;
    drain(12);
    chk("rst_residual", 32'(vc8), 32'd0);

    // LSB first
    vcl = 0;
    send(1, 8'h0D, w);
    idle();
    drain(12);
    chk("lsb_valid_cycles", 32'(vcl), 32'd8);

    // WIDTH=4 back-to-back
    vc4 = 0; l4 = 0; m4 = 0; n4 = 0;
    send(2, 8'h0B, w);
    send(2, 8'h0B, w);
    idle();
    drain(12);
    chk("w4_valid_cycles", 32'(vc4), 32'd8);
    chk("w4_last_pulses", 32'(l4), 32'd2);
    chk("w4_matches", 32'(m4), 32'd2);

    // random words under random stall
    vc8 = 0;
    fork
      begin
        for (int k = 0; k < 6; k++) send(0, 8'($urandom), w);
        idle();
      end
      begin
        repeat (80) begin
          @(posedge clk);
          #1;
          st = 1'($urandom_range(0, 1));
        end
        st = 1'b0;
      end
    join
    drain(60);
    chk("rand_valid_cycles", 32'(vc8 >= 48), 32'd1);
    chk("rand_drained", 32'(q8.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Upstream feeder for the 1011 sequence detector.
- Accepts parallel words over a valid/ready handshake and emits them one bit per clock on out_bit; out_bit drives the detector's inp_bit.
- A one-entry holding register allows back-to-back words with no bubble on the serial side.
- A stall input freezes the serial stream without losing data.

Parameters:
- WIDTH, 8, bits per parallel word (legal range 2..32).
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on posedge clk).
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- stall  input  1  1 = hold the current serial bit; no advance.
- out_bit  output  1  current serial bit (feeds detector inp_bit).
- out_valid  output  1  out_bit carries a real data bit.
- out_last  output  1  out_bit is the final bit of its word.

Behaviour:
- Reset (reset==0 at posedge):
  - FSM goes to IDLE; hold_full=0; shift register and bit counter = 0.
  - out_bit=0, out_valid=0, out_last=0.
  - in_ready is 0 while reset is low. Words offered during reset are dropped.
  - Reset mid-word discards both the partial word and the held word.
- in_ready = reset & ~hold_full. It has no combinational dependence on in_valid or stall.
- Accept occurs at a posedge with in_valid & in_ready.
- FSM states:
  - IDLE: out_valid=0. On accept, load in_data into the shift register, cnt=0, go to SHIFT.
  - SHIFT: out_valid=1.
    - Each posedge with stall==0 advances one bit (cnt+1).
    - When cnt==WIDTH-1 and stall==0 (last bit consumed):
      - if hold_full: load the held word, cnt=0, hold_full=0, stay in SHIFT;
      - else if accept this edge: load in_data directly, stay in SHIFT;
      - else go to IDLE.
    - Otherwise an accept in SHIFT writes the hold register (hold_full=1).
- Latency: a word accepted at edge N shows its first bit at out_bit in cycle N+1 when the block was idle.
- A word of WIDTH bits occupies exactly WIDTH non-stalled cycles.
- Back-to-back words produce contiguous out_valid with no gap.
- Bit order:
  - MSB_FIRST=1: out_bit = sreg[WIDTH-1], shift left.
  - MSB_FIRST=0: out_bit = sreg[0], shift right.
  - Fill bits are 0.
- out_bit is forced to 0 when out_valid=0.
- out_last = out_valid & (cnt==WIDTH-1).
- stall:
  - Holds out_bit, out_last and cnt unchanged.
  - Has no effect in IDLE.
  - Does not block an accept into an empty shift register or into an empty hold register.
- Simultaneous accept with the last-bit edge while hold_full=1 cannot occur, because in_ready=0 in that case.
- cnt width is $clog2(WIDTH). cnt never exceeds WIDTH-1.

Decomposition:
- Package seq_pkg holds:
  - enum ser_state_t {SER_IDLE, SER_SHIFT};
  - localparam SEQ_PATTERN = 4'b1011 (shared with the detector bench).
- Sub-module seq_hold_reg: the one-entry holding buffer.
  - Ports: clk, reset, wr_en, wr_data, rd_en, rd_data, full.
  - It keeps the handshake bookkeeping out of the shifter FSM.

Test Plan:
- Single word, MSB_FIRST=1, WIDTH=8, in_data=8'hB0 accepted at edge 1:
  - out_bit is 1,0,1,1,0,0,0,0 on cycles 2..9;
  - out_last=1 on cycle 9 only;
  - out_valid=0 on cycle 10;
  - a connected detector raises seq_seen one cycle after the fourth bit.
- Back-to-back 8'hB0, 8'h0B, 8'hFF with in_valid held high:
  - 24 contiguous out_valid cycles;
  - in_ready drops to 0 after the second accept and returns to 1 on the edge the held word loads;
  - bit stream matches concatenated MSB-first.
- Stall on the 3rd bit of 8'hB0 for 4 cycles:
  - out_bit holds 1 and cnt holds 2 for 4 cycles, then the stream resumes 1,0,0,0,0;
  - total valid cycles = 12.
- Reset driven low for one cycle mid-word (after 5 bits of 8'hB0) with hold full:
  - next cycle out_valid=0, out_bit=0, in_ready=0;
  - after reset releases, in_ready=1 and no residual bits are emitted.
- MSB_FIRST=0, in_data=8'h0D: out_bit is 1,0,1,1,0,0,0,0 (LSB first).
- WIDTH=4 boundary, words 4'hB then 4'hB back-to-back:
  - stream is 1011 1011;
  - detector sees two overlapping-allowed matches, and out_last pulses on cycles 5 and 9.
